// File: rtl/ap_precharge_tracker.sv
// ap_precharge_tracker
// Tracks auto-precharge / explicit precharge progress for every bank of every
// rank. Each bank runs a small IDLE -> PENDING -> COUNTING machine: a setup
// reserves the bank and latches the precharge source, the PHY ack starts a
// down-counter loaded from that source, and the bank frees itself when the
// counter expires. Busy/counting status per bank and idle status per rank are
// exported; illegal setups and acks raise one-cycle error pulses. The block
// never issues DRAM commands itself.
module ap_precharge_tracker #(
   parameter int NUMRANK      = 2,
   parameter int NUMBANK      = 4,
   parameter int NUMBANKGROUP = 4,
   parameter int TOTALBANKS   = NUMBANK * NUMBANKGROUP,
   parameter int tRP          = 16,
   parameter int tWR          = 18,
   parameter int tRTP         = 8,
   parameter int RW           = (NUMRANK > 1) ? $clog2(NUMRANK) : 1,
   parameter int BW           = $clog2(TOTALBANKS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          apSetup,
   input  logic [1:0]                    setupMode,
   input  logic [RW-1:0]                 setupRank,
   input  logic [BW-1:0]                 setupBGBK,
   input  logic                          apAck,
   input  logic [RW-1:0]                 ackRank,
   input  logic [BW-1:0]                 ackBGBK,
   output logic [NUMRANK*TOTALBANKS-1:0] bankBusy,
   output logic [NUMRANK*TOTALBANKS-1:0] bankCounting,
   output logic [NUMRANK-1:0]            rankIdle,
   output logic                          errSetup,
   output logic                          errAck
);

   localparam int NB = NUMRANK * TOTALBANKS;
   // Counter must hold the largest load (write recovery plus precharge).
   localparam int CW = $clog2(tWR + tRP + 1);

   // Precharge source encodings carried on setupMode.
   localparam logic [1:0] MODE_RDA = 2'd0;
   localparam logic [1:0] MODE_WRA = 2'd1;
   localparam logic [1:0] MODE_PRE = 2'd2;
   localparam logic [1:0] MODE_RSV = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PENDING  = 2'd1,
      ST_COUNTING = 2'd2
   } bank_state_e;

   // Per-bank architectural state.
   bank_state_e   state_r [NB];
   logic [1:0]    mode_r  [NB];
   logic [CW-1:0] cnt_r   [NB];

   // Next-state values computed combinationally.
   bank_state_e   state_s [NB];
   logic [1:0]    mode_s  [NB];
   logic [CW-1:0] cnt_s   [NB];

   // Registered outputs and their next values.
   logic [NB-1:0] busy_r;
   logic [NB-1:0] counting_r;
   logic          err_setup_r;
   logic          err_ack_r;
   logic [NB-1:0] busy_s;
   logic [NB-1:0] counting_s;
   logic          err_setup_s;
   logic          err_ack_s;

   // Request decode.
   logic [NB-1:0] setup_hit_s;
   logic [NB-1:0] ack_hit_s;
   logic [NB-1:0] idle_vec_s;
   logic [NB-1:0] pend_vec_s;
   logic          setup_ok_s;
   logic          ack_ok_s;

   // Counter load for a given precharge source; reserved maps to the
   // shortest load so a corrupted mode can never stall a bank for long.
   function automatic logic [CW-1:0] load_value(input logic [1:0] mode);
      logic [CW-1:0] val;
      case (mode)
         MODE_RDA: val = CW'(tRTP + tRP);
         MODE_WRA: val = CW'(tWR + tRP);
         MODE_PRE: val = CW'(tRP);
         default:  val = CW'(tRP);
      endcase
      return val;
   endfunction

   // Decode which bank the setup and ack address; out-of-range ranks match
   // no bank, which makes them fall into the rejection path naturally.
   always_comb begin
      setup_hit_s = '0;
      ack_hit_s   = '0;
      idle_vec_s  = '0;
      pend_vec_s  = '0;
      for (int r = 0; r < NUMRANK; r++) begin
         for (int b = 0; b < TOTALBANKS; b++) begin
            setup_hit_s[r*TOTALBANKS+b] = (setupRank == RW'(r)) && (setupBGBK == BW'(b));
            ack_hit_s[r*TOTALBANKS+b]   = (ackRank == RW'(r)) && (ackBGBK == BW'(b));
         end
      end
      for (int i = 0; i < NB; i++) begin
         idle_vec_s[i] = (state_r[i] == ST_IDLE);
         pend_vec_s[i] = (state_r[i] == ST_PENDING);
      end
      // Both decisions use pre-edge state, so a bank completing this cycle
      // is still COUNTING and rejects a setup, and an IDLE bank receiving a
      // setup rejects a simultaneous ack.
      setup_ok_s  = apSetup && (setupMode != MODE_RSV) && (|(setup_hit_s & idle_vec_s));
      ack_ok_s    = apAck && (|(ack_hit_s & pend_vec_s));
      err_setup_s = apSetup && !setup_ok_s;
      err_ack_s   = apAck && !ack_ok_s;
   end

   // Per-bank next-state logic and next values of the registered status.
   always_comb begin
      busy_s     = '0;
      counting_s = '0;
      for (int i = 0; i < NB; i++) begin
         state_s[i] = state_r[i];
         mode_s[i]  = mode_r[i];
         cnt_s[i]   = cnt_r[i];
         case (state_r[i])
            ST_IDLE: begin
               cnt_s[i] = {CW{1'b0}};
               if (setup_ok_s && setup_hit_s[i]) begin
                  state_s[i] = ST_PENDING;
                  mode_s[i]  = setupMode;
               end else begin
                  state_s[i] = ST_IDLE;
               end
            end
            ST_PENDING: begin
               if (ack_ok_s && ack_hit_s[i]) begin
                  state_s[i] = ST_COUNTING;
                  cnt_s[i]   = load_value(mode_r[i]);
               end else begin
                  state_s[i] = ST_PENDING;
               end
            end
            ST_COUNTING: begin
               // A zero count can only come from corruption; treat it as
               // expiry rather than wrapping to the maximum.
               if (cnt_r[i] <= CW'(1)) begin
                  state_s[i] = ST_IDLE;
                  cnt_s[i]   = {CW{1'b0}};
               end else begin
                  state_s[i] = ST_COUNTING;
                  cnt_s[i]   = cnt_r[i] - CW'(1);
               end
            end
            default: begin
               state_s[i] = ST_IDLE;
               mode_s[i]  = 2'd0;
               cnt_s[i]   = {CW{1'b0}};
            end
         endcase
         busy_s[i]     = (state_s[i] != ST_IDLE);
         counting_s[i] = (state_s[i] == ST_COUNTING);
      end
   end

   // State, counters, stored modes and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NB; i++) begin
            state_r[i] <= ST_IDLE;
            mode_r[i]  <= 2'd0;
            cnt_r[i]   <= {CW{1'b0}};
         end
         busy_r      <= '0;
         counting_r  <= '0;
         err_setup_r <= 1'b0;
         err_ack_r   <= 1'b0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            state_r[i] <= state_s[i];
            mode_r[i]  <= mode_s[i];
            cnt_r[i]   <= cnt_s[i];
         end
         busy_r      <= busy_s;
         counting_r  <= counting_s;
         err_setup_r <= err_setup_s;
         err_ack_r   <= err_ack_s;
      end
   end

   // Rank is idle when none of its banks is busy.
   always_comb begin
      rankIdle = '0;
      for (int r = 0; r < NUMRANK; r++) begin
         rankIdle[r] = ~(|busy_r[r*TOTALBANKS +: TOTALBANKS]);
      end
   end

   assign bankBusy     = busy_r;
   assign bankCounting = counting_r;
   assign errSetup     = err_setup_r;
   assign errAck       = err_ack_r;

endmodule

// File: tb/tb_ap_precharge_tracker.sv
// Directed bench for ap_precharge_tracker (2 ranks x 16 banks, tRP=16,
// tWR=18, tRTP=8): a vector table for single-cycle behaviour and errors,
// then hand-written sequences for the multi-cycle timing corners.
module tb_ap_precharge_tracker;

   logic        clk = 1'b0;
   logic        rst;
   logic        apSetup;
   logic [1:0]  setupMode;
   logic        setupRank;
   logic [3:0]  setupBGBK;
   logic        apAck;
   logic        ackRank;
   logic [3:0]  ackBGBK;
   logic [31:0] bankBusy;
   logic [31:0] bankCounting;
   logic [1:0]  rankIdle;
   logic        errSetup;
   logic        errAck;

   int errors = 0;
   int checks = 0;

   ap_precharge_tracker dut (
      .clk(clk), .rst(rst),
      .apSetup(apSetup), .setupMode(setupMode), .setupRank(setupRank), .setupBGBK(setupBGBK),
      .apAck(apAck), .ackRank(ackRank), .ackBGBK(ackBGBK),
      .bankBusy(bankBusy), .bankCounting(bankCounting), .rankIdle(rankIdle),
      .errSetup(errSetup), .errAck(errAck)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [1:0]  sm;
      logic        sr;
      logic [3:0]  sb;
      logic        a;
      logic        ar;
      logic [3:0]  ab;
      logic [31:0] busy;
      logic [31:0] cnt;
      logic [1:0]  ri;
      logic        es;
      logic        ea;
   } vec_t;

   vec_t tbl [9];

   function automatic logic [31:0] bit_of(input int i);
      logic [31:0] one;
      one = 32'd1;
      return one << i;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] b, input logic [31:0] c,
                            input logic [1:0] ri, input logic es, input logic ea);
      chk({tag, " busy"}, bankBusy, b);
      chk({tag, " counting"}, bankCounting, c);
      chk({tag, " rankIdle"}, {30'd0, rankIdle}, {30'd0, ri});
      chk({tag, " errSetup"}, {31'd0, errSetup}, {31'd0, es});
      chk({tag, " errAck"}, {31'd0, errAck}, {31'd0, ea});
   endtask

   task automatic clear_in();
      apSetup = 1'b0; setupMode = 2'd0; setupRank = 1'b0; setupBGBK = 4'd0;
      apAck = 1'b0; ackRank = 1'b0; ackBGBK = 4'd0;
   endtask

   task automatic do_setup(input logic r, input logic [3:0] b, input logic [1:0] m);
      apSetup = 1'b1; setupRank = r; setupBGBK = b; setupMode = m;
   endtask

   task automatic do_ack(input logic r, input logic [3:0] b);
      apAck = 1'b1; ackRank = r; ackBGBK = b;
   endtask

   // Advance one edge, sample 1 time unit later, then drop the strobes.
   task automatic tick();
      @(posedge clk);
      #1;
      clear_in();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [31:0] eb;
   logic [31:0] ec;
   logic        on_a;
   logic        on_b;

   initial begin
      // Table: each row is driven for one edge and checked after it.
      tbl[0] = '{1'b0, 2'd0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 32'h0000_0000, 32'h0000_0000, 2'b11, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 2'd2, 1'b0, 4'd3,  1'b0, 1'b0, 4'd0, 32'h0000_0008, 32'h0000_0000, 2'b10, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 2'd0, 1'b0, 4'd3,  1'b0, 1'b0, 4'd0, 32'h0000_0008, 32'h0000_0000, 2'b10, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 2'd3, 1'b0, 4'd4,  1'b0, 1'b0, 4'd0, 32'h0000_0008, 32'h0000_0000, 2'b10, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 2'd0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd7, 32'h0000_0008, 32'h0000_0000, 2'b10, 1'b0, 1'b1};
      tbl[5] = '{1'b0, 2'd0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd3, 32'h0000_0008, 32'h0000_0008, 2'b10, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 2'd0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd3, 32'h0000_0008, 32'h0000_0008, 2'b10, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 2'd1, 1'b1, 4'd2,  1'b1, 1'b1, 4'd2, 32'h0004_0008, 32'h0000_0008, 2'b00, 1'b0, 1'b1};
      tbl[8] = '{1'b1, 2'd0, 1'b1, 4'd2,  1'b1, 1'b1, 4'd2, 32'h0004_0008, 32'h0004_0008, 2'b00, 1'b1, 1'b0};

      clear_in();
      do_reset();
      check_all("reset", 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);

      for (int i = 0; i < 9; i++) begin
         apSetup = tbl[i].s; setupMode = tbl[i].sm; setupRank = tbl[i].sr; setupBGBK = tbl[i].sb;
         apAck = tbl[i].a; ackRank = tbl[i].ar; ackBGBK = tbl[i].ab;
         tick();
         check_all($sformatf("vec%0d", i), tbl[i].busy, tbl[i].cnt, tbl[i].ri, tbl[i].es, tbl[i].ea);
      end

      // Continue: bank 3 (PRE, acked at row 5 = T) frees at T+16 despite the
      // ignored re-ack; a setup on T+16 is rejected, on T+17 accepted.
      // Bank 18 (WRA, acked at T+3) frees at T+37.
      for (int k = 4; k <= 40; k++) begin
         if (k == 16 || k == 17) do_setup(1'b0, 4'd3, 2'd2);
         tick();
         on_a = (k < 16) || (k >= 17);
         on_b = (k < 37);
         eb = (on_a ? bit_of(3) : 32'h0) | (on_b ? bit_of(18) : 32'h0);
         ec = ((k < 16) ? bit_of(3) : 32'h0) | (on_b ? bit_of(18) : 32'h0);
         check_all($sformatf("seqA k%0d", k), eb, ec, {~on_b, ~on_a}, (k == 16), 1'b0);
      end

      // RDA on rank0 bank5: L = tRTP+tRP = 24.
      do_reset();
      do_setup(1'b0, 4'd5, 2'd0);
      tick();
      check_all("rda setup", bit_of(5), 32'h0, 2'b10, 1'b0, 1'b0);
      tick();
      tick();
      check_all("rda pending", bit_of(5), 32'h0, 2'b10, 1'b0, 1'b0);
      do_ack(1'b0, 4'd5);
      tick();
      check_all("rda ack", bit_of(5), bit_of(5), 2'b10, 1'b0, 1'b0);
      for (int k = 1; k <= 24; k++) begin
         tick();
         eb = (k < 24) ? bit_of(5) : 32'h0;
         check_all($sformatf("rda k%0d", k), eb, eb, (k < 24) ? 2'b10 : 2'b11, 1'b0, 1'b0);
      end

      // WRA on rank1 bank0 acked at T together with a setup of bank15;
      // PRE on bank15 acked at T+1. Bank31 frees at T+17, bank16 at T+34.
      do_reset();
      do_setup(1'b1, 4'd0, 2'd1);
      tick();
      check_all("par setup0", bit_of(16), 32'h0, 2'b01, 1'b0, 1'b0);
      do_setup(1'b1, 4'd15, 2'd2);
      do_ack(1'b1, 4'd0);
      tick();
      check_all("par T", bit_of(16) | bit_of(31), bit_of(16), 2'b01, 1'b0, 1'b0);
      do_ack(1'b1, 4'd15);
      tick();
      check_all("par T1", bit_of(16) | bit_of(31), bit_of(16) | bit_of(31), 2'b01, 1'b0, 1'b0);
      for (int k = 2; k <= 35; k++) begin
         tick();
         on_a = (k < 34);
         on_b = (k < 17);
         eb = (on_a ? bit_of(16) : 32'h0) | (on_b ? bit_of(31) : 32'h0);
         check_all($sformatf("par k%0d", k), eb, eb, {~(on_a | on_b), 1'b1}, 1'b0, 1'b0);
      end

      // Three banks reach counter 10 together, then reset mid-count.
      do_reset();
      do_setup(1'b0, 4'd1, 2'd1);
      tick();
      do_setup(1'b1, 4'd6, 2'd0);
      tick();
      do_setup(1'b0, 4'd12, 2'd2);
      tick();
      do_ack(1'b0, 4'd1);
      tick();
      for (int k = 1; k <= 24; k++) begin
         if (k == 10) do_ack(1'b1, 4'd6);
         if (k == 18) do_ack(1'b0, 4'd12);
         tick();
      end
      eb = bit_of(1) | bit_of(12) | bit_of(22);
      check_all("pre rst", eb, eb, 2'b00, 1'b0, 1'b0);
      rst = 1'b1;
      do_setup(1'b0, 4'd3, 2'd3);
      do_ack(1'b0, 4'd7);
      tick();
      rst = 1'b0;
      check_all("mid rst", 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
      for (int k = 0; k < 12; k++) tick();
      check_all("post rst quiet", 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
      do_setup(1'b0, 4'd1, 2'd2);
      tick();
      do_ack(1'b0, 4'd1);
      tick();
      check_all("fresh ack", bit_of(1), bit_of(1), 2'b10, 1'b0, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         tick();
         eb = (k < 16) ? bit_of(1) : 32'h0;
         check_all($sformatf("fresh k%0d", k), eb, eb, (k < 16) ? 2'b10 : 2'b11, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ap_precharge_tracker.md
Name: ap_precharge_tracker

Overview:
- Multi-rank successor to the single-rank auto-precharge timer in the backend rank scheduler.
- Tracks precharge-in-progress per bank, per rank, for three precharge sources: RDA (tRTP+tRP), WRA (tWR+tRP) and explicit PRE (tRP).
- Exposes per-bank blocking and per-rank idle status to the rank FSMs and the refresh logic.
- Flags protocol violations. Issues no DRAM commands.

Parameters:
- NUMRANK, 2, ranks tracked.
- NUMBANK, 4, banks per bank group.
- NUMBANKGROUP, 4, bank groups per rank.
- TOTALBANKS, NUMBANK*NUMBANKGROUP, banks per rank.
- tRP, 16, precharge time in cycles (>=1).
- tWR, 18, write recovery in cycles.
- tRTP, 8, read-to-precharge in cycles.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, synchronous reset, active-high.
- apSetup, in, 1, reserve a bank for precharge (from rank FSM).
- setupMode, in, 2, 0=RDA, 1=WRA, 2=PRE, 3=reserved.
- setupRank, in, max(1,$clog2(NUMRANK)), rank of the reservation.
- setupBGBK, in, $clog2(TOTALBANKS), {BG,BK} of the reservation.
- apAck, in, 1, PHY acknowledges the command was issued.
- ackRank, in, max(1,$clog2(NUMRANK)), rank of the ack.
- ackBGBK, in, $clog2(TOTALBANKS), {BG,BK} of the ack.
- bankBusy, out, NUMRANK*TOTALBANKS, 1 = bank PENDING or COUNTING; index r*TOTALBANKS+b.
- bankCounting, out, NUMRANK*TOTALBANKS, 1 = bank COUNTING.
- rankIdle, out, NUMRANK, 1 = no busy bank in that rank.
- errSetup, out, 1, one-cycle pulse: setup rejected.
- errAck, out, 1, one-cycle pulse: ack ignored.

Behaviour:
- Per-bank FSM, states IDLE, PENDING, COUNTING. Each bank also holds a 2-bit stored mode and a down-counter.
- Counter width is $clog2(tWR+tRP+1), covering the largest load.
- Load value L: RDA = tRTP+tRP, WRA = tWR+tRP, PRE = tRP. L is taken from the stored mode at ack time.
- Reset (rst=1 at an edge): all banks go IDLE, counters 0, stored modes 0. Outputs then read bankBusy=0, bankCounting=0, rankIdle=all 1, errSetup=0, errAck=0.
- Reset mid-operation discards all pending and counting state. No completion is reported.
- IDLE -> PENDING:
  - Condition: apSetup=1 for this bank, target IDLE, setupMode!=3.
  - The mode is stored. bankBusy rises on the next edge.
- Setup rejection: any of the following ignores the setup, leaves state unchanged and pulses errSetup in the next cycle.
  - Target bank not IDLE, including a bank completing COUNTING in the same cycle.
  - setupMode=3.
  - setupRank>=NUMRANK.
- PENDING -> COUNTING:
  - Condition: apAck=1 for this bank while PENDING.
  - Counter <= L and bankCounting rises next edge.
- Ack rejection: ack to an IDLE or COUNTING bank, or ackRank>=NUMRANK, is ignored and pulses errAck next cycle.
- COUNTING: the counter decrements by 1 each cycle.
  - At the edge where counter==1 the bank returns to IDLE.
  - bankBusy and bankCounting therefore fall exactly L edges after the edge sampling apAck.
  - Counter is 0 in IDLE.
- Latency: ack sampled at edge T -> bank free (setup accepted) from edge T+L onward.
- Simultaneous setup and ack in one cycle:
  - Different banks: both take effect independently.
  - Same bank, PENDING: ack takes effect; setup is rejected (errSetup).
  - Same bank, IDLE: setup accepted; ack rejected (errAck). Ack is evaluated against the pre-edge state.
- Completion on one bank and setup on another in the same cycle: both take effect.
- PENDING has no timeout; the bank stays PENDING until acked or reset.
- rankIdle[r] = NOR of bankBusy for rank r, combinational from registered state.
- All outputs except rankIdle are registered.
- Any number of banks may count concurrently; counters are fully independent.
- NUMRANK=1: rank inputs are 1 bit wide; value 1 is out of range and triggers the rejection rules.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> bankBusy=0, bankCounting=0, rankIdle=2'b11, no err pulses.
- RDA timing:
  - Stimulus: setup rank0 BGBK=5 mode0, ack 3 cycles later at edge T.
  - Required: bankBusy[5] high from setup+1 edge; bankCounting[5] high T+1..T+23; both low at T+24; rankIdle[0] low throughout.
- WRA and PRE in parallel:
  - Stimulus: rank1 BGBK=0 mode1 and rank1 BGBK=15 mode2 acked on the same edge T (setups on different earlier cycles).
  - Required: bank16+15 frees at T+16; bank16+0 frees at T+34; rankIdle[1] rises at T+34.
- Errors:
  - Setup to a PENDING bank -> errSetup pulse, state unchanged.
  - setupMode=3 -> errSetup.
  - Ack to an IDLE bank -> errAck.
  - Ack to a COUNTING bank -> errAck, counter not reloaded.
- Same-cycle same-bank:
  - Setup+ack to a PENDING bank -> COUNTING plus errSetup.
  - Setup on the exact edge a bank completes (counter==1) -> rejected; the same setup one cycle later is accepted.
- Reset mid-count:
  - Stimulus: assert rst while 3 banks are COUNTING with counter=10.
  - Required: all outputs at reset values next cycle; a fresh setup+ack gives the full L.
